m_cp0: RTL and testbench
========================

Name: m_cp0

Overview:
- Coprocessor 0 of the pipelined MIPS core. Sits in the M stage and holds SR, Cause, EPC and PRId.
- Detects interrupts and exceptions, records EPC and cause, and produces the exception request that flushes the pipeline.
- Supplies EPC to the eret redirect path.
- Supplies mfc0 read data, which travels down the M/W register to the W stage. The W stage selects it onto the GRF write port for mfc0.

Parameters:
- PRID, 32'h5A5A_2022, read-only value returned for register 15.
- HW_INT_W, 6, number of hardware interrupt lines (maps to IP[15:10]).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all CP0 state
- rd_addr  in  5  mfc0 source register number
- wr_addr  in  5  mtc0 destination register number
- wr_data  in  32  mtc0 data (forwarded rt value)
- we  in  1  mtc0 write enable from M-stage control
- pc  in  32  PC of the instruction currently in M
- bd  in  1  M instruction is in a branch/jump delay slot
- exc_code  in  5  pending exception code from M (0 = none)
- exl_clr  in  1  eret in M
- hw_int  in  HW_INT_W  external interrupt lines, level-sensitive
- req  out  1  take exception/interrupt this cycle (combinational)
- epc_out  out  32  current EPC register
- rd_data  out  32  mfc0 read data (combinational)

Behaviour:
- Reset (async): SR, Cause and EPC are all 0. Outputs settle to req=0, epc_out=0, and rd_data per rd_addr (PRID for 15, otherwise 0).
- SR (12) has these live bits: IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause (13) has these live bits: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- EPC (14) is 32 bits. PRId (15) returns PRID. Any other rd_addr returns 0.
- Interrupt condition: int_req = IE & ~EXL & |(IM & hw_int).
- Exception condition: exc_req = (exc_code != 0) & ~EXL.
- req = int_req | exc_req. Interrupt has priority over exception.
- IP is sampled every cycle: Cause.IP <= hw_int, regardless of any other event.
- On a rising edge with req=1:
  - EXL <= 1.
  - Cause.BD <= bd.
  - ExcCode <= 0 if int_req, else exc_code.
  - EPC <= bd ? (pc - 4) : pc, with bits [1:0] forced to 0.
  - Any mtc0 in the same cycle is discarded.
- On a rising edge with req=0 and exl_clr=1: EXL <= 0. If we=1 in the same cycle, the write still applies; eret and mtc0 are never co-issued, but if they are, the SR write is applied first and then EXL is cleared.
- On a rising edge with req=0 and we=1:
  - wr_addr 12 writes IM, EXL and IE from wr_data.
  - wr_addr 14 writes EPC from wr_data[31:2],2'b00.
  - Writes to Cause, PRId or unimplemented numbers are ignored.
- Priority order: req > exl_clr > we.
- No read bypass: rd_data and epc_out reflect register state before the current edge. Hazard logic stalls eret while an mtc0 to EPC is in M/W.
- EXL=1 masks both interrupts and new exceptions. This guarantees req=0 while eret (executing at EXL=1) is in M.
- pc - 4 wraps modulo 2^32.
- Reset asserted mid-operation clears state immediately; req drops asynchronously with it.

Decomposition:
- Shared package / header holds:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - ExcCode values: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - Field bit positions: IM, EXL, IE, BD, IP, ExcCode.
  - Handler entry address 32'h0000_4180 (used by the PC logic, not this block).
- No sub-module. Register file, request logic and read mux together are about 150 lines.

Test Plan:
- Reset asserted, then released → rd_addr 12/13/14 read 0, rd_addr 15 reads PRID, req=0.
- mtc0 12 with 32'h0000_0401 (IM[10]=1, IE=1), then hw_int=6'b000001 → req=1 that cycle. After the edge: Cause=32'h0000_0400 with ExcCode 0, EXL=1, EPC=pc.
- exc_code=12 (Ov), bd=1, pc=32'h0000_3008, EXL=0 → req=1. After the edge: EPC=32'h0000_3004, Cause[31]=1, Cause[6:2]=12.
- EXL=1 with exc_code=10 and hw_int enabled → req=0. EPC unchanged, IP still tracks hw_int.
- Same cycle: exc_code=8, we=1, wr_addr 14, wr_data=32'hDEAD_BEEF → EPC=pc (the write is dropped). Then exl_clr=1 → EXL=0 next cycle.
- mtc0 14 with 32'h0000_3017, then read 14 → 32'h0000_3014. mtc0 13 with 32'hFFFF_FFFF → Cause unchanged.

Source files
------------

// File: rtl/m_cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// field positions and the exception handler entry address.
package m_cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int IM_LSB  = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_LSB  = 10;
    localparam int EXC_LSB = 2;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/m_cp0_if.sv
// M-stage <-> CP0 bundle: mfc0/mtc0 access, exception inputs,
// and the request / EPC / read-data results.
interface m_cp0_if #(
    parameter int HW_INT_W = 6
);
    logic [4:0]          rd_addr;
    logic [4:0]          wr_addr;
    logic [31:0]         wr_data;
    logic                we;
    logic [31:0]         pc;
    logic                bd;
    logic [4:0]          exc_code;
    logic                exl_clr;
    logic [HW_INT_W-1:0] hw_int;
    logic                req;
    logic [31:0]         epc_out;
    logic [31:0]         rd_data;

    modport master (
        output rd_addr, wr_addr, wr_data, we, pc, bd,
        output exc_code, exl_clr, hw_int,
        input  req, epc_out, rd_data
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, we, pc, bd,
        input  exc_code, exl_clr, hw_int,
        output req, epc_out, rd_data
    );
endinterface

// File: rtl/m_cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception
// request generation, mfc0 read mux and EPC for eret.
module m_cp0
    import m_cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h5A5A_2022,
    parameter int          HW_INT_W = 6
) (
    input  logic  clk,
    input  logic  reset,
    m_cp0_if.slave bus
);

    logic [HW_INT_W-1:0] im;
    logic [HW_INT_W-1:0] ip;
    logic                exl;
    logic                ie;
    logic                bd_r;
    logic [4:0]          exc_r;
    logic [31:0]         epc;

    logic                int_req;
    logic                exc_req;
    logic [31:0]         epc_n;
    logic [31:0]         sr_val;
    logic [31:0]         cause_val;

    assign int_req = ie & ~exl & (|(im & bus.hw_int));
    assign exc_req = (bus.exc_code != 5'd0) & ~exl;
    assign bus.req = int_req | exc_req;

    // Restart point is the branch when the faulting insn sits in its slot
    assign epc_n = bus.bd ? (bus.pc - 32'd4) : bus.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im    <= '0;
            ip    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd_r  <= 1'b0;
            exc_r <= 5'd0;
            epc   <= 32'd0;
        end else begin
            ip <= bus.hw_int;
            if (bus.req) begin
                exl   <= 1'b1;
                bd_r  <= bus.bd;
                exc_r <= int_req ? 5'd0 : bus.exc_code;
                epc   <= {epc_n[31:2], 2'b00};
            end else begin
                if (bus.we) begin
                    if (bus.wr_addr == CP0_SR) begin
                        im  <= bus.wr_data[IM_LSB +: HW_INT_W];
                        exl <= bus.wr_data[EXL_BIT];
                        ie  <= bus.wr_data[IE_BIT];
                    end
                    if (bus.wr_addr == CP0_EPC)
                        epc <= {bus.wr_data[31:2], 2'b00};
                end
                // eret wins over a co-issued SR write to EXL
                if (bus.exl_clr)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_val                       = 32'd0;
        sr_val[IM_LSB +: HW_INT_W]   = im;
        sr_val[EXL_BIT]              = exl;
        sr_val[IE_BIT]               = ie;
        cause_val                    = 32'd0;
        cause_val[BD_BIT]            = bd_r;
        cause_val[IP_LSB +: HW_INT_W] = ip;
        cause_val[EXC_LSB +: 5]      = exc_r;
    end

    always_comb begin
        bus.rd_data = 32'd0;
        unique case (1'b1)
            (bus.rd_addr == CP0_SR):    bus.rd_data = sr_val;
            (bus.rd_addr == CP0_CAUSE): bus.rd_data = cause_val;
            (bus.rd_addr == CP0_EPC):   bus.rd_data = epc;
            (bus.rd_addr == CP0_PRID):  bus.rd_data = PRID;
            default:                    bus.rd_data = 32'd0;
        endcase
    end

    assign bus.epc_out = epc;

endmodule

// File: tb/tb_m_cp0.sv
// Directed vector bench for m_cp0: per-cycle request check and
// post-edge SR/Cause/EPC readback, plus reset corner sequences.
module tb_m_cp0;

    localparam logic [31:0] PRID = 32'h5A5A_2022;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    m_cp0_if #(.HW_INT_W(6)) bus ();

    m_cp0 #(.PRID(PRID), .HW_INT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        clr;
        logic [5:0]  hw;
        logic        req;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        bus.rd_addr = a;
        #1;
        v = bus.rd_data;
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'd0;
        bus.pc       = 32'd0;
        bus.bd       = 1'b0;
        bus.exc_code = 5'd0;
        bus.exl_clr  = 1'b0;
        bus.hw_int   = 6'd0;
    endtask

    logic [31:0] v;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.rd_addr = 5'd12;
        idle();

        vecs[0]  = '{1'b1, 5'd12, 32'h0000_0401, 32'h0000_0100, 1'b0, 5'd0,  1'b0, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         32'h0000_1000, 1'b0, 5'd0,  1'b0, 6'b000001,
                     1'b1, 32'h0000_0403, 32'h0000_0400, 32'h0000_1000};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         32'h0000_1004, 1'b0, 5'd0,  1'b1, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h0000_0000, 32'h0000_1000};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         32'h0000_3008, 1'b1, 5'd12, 1'b0, 6'b000000,
                     1'b1, 32'h0000_0403, 32'h8000_0030, 32'h0000_3004};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         32'h0000_5000, 1'b0, 5'd10, 1'b0, 6'b000001,
                     1'b0, 32'h0000_0403, 32'h8000_0430, 32'h0000_3004};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         32'h0000_5004, 1'b0, 5'd0,  1'b1, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h8000_0030, 32'h0000_3004};
        vecs[6]  = '{1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_2000, 1'b0, 5'd8,  1'b0, 6'b000000,
                     1'b1, 32'h0000_0403, 32'h0000_0020, 32'h0000_2000};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         32'h0000_2004, 1'b0, 5'd0,  1'b1, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h0000_0020, 32'h0000_2000};
        vecs[8]  = '{1'b1, 5'd14, 32'h0000_3017, 32'h0000_2008, 1'b0, 5'd0,  1'b0, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h0000_0020, 32'h0000_3014};
        vecs[9]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_200C, 1'b0, 5'd0,  1'b0, 6'b000000,
                     1'b0, 32'h0000_0401, 32'h0000_0020, 32'h0000_3014};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         32'h0000_0002, 1'b1, 5'd4,  1'b0, 6'b000000,
                     1'b1, 32'h0000_0403, 32'h8000_0010, 32'hFFFF_FFFC};
        vecs[11] = '{1'b1, 5'd12, 32'hA0A0_0C03, 32'h0000_0010, 1'b0, 5'd0,  1'b1, 6'b000000,
                     1'b0, 32'h0000_0C01, 32'h8000_0010, 32'hFFFF_FFFC};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         32'h0000_4003, 1'b0, 5'd12, 1'b0, 6'b000010,
                     1'b1, 32'h0000_0C03, 32'h0000_0800, 32'h0000_4000};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         32'h0000_4004, 1'b0, 5'd0,  1'b1, 6'b000100,
                     1'b0, 32'h0000_0C01, 32'h0000_1000, 32'h0000_4000};
        vecs[14] = '{1'b0, 5'd0,  32'h0,         32'h0000_4008, 1'b0, 5'd0,  1'b0, 6'b000100,
                     1'b0, 32'h0000_0C01, 32'h0000_1000, 32'h0000_4000};

        // reset state while asserted and after release
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'd0, bus.req}, 32'd0);
        rd(5'd12, v); check("rst_sr", v, 32'd0);
        rd(5'd13, v); check("rst_cause", v, 32'd0);
        rd(5'd14, v); check("rst_epc", v, 32'd0);
        rd(5'd15, v); check("rst_prid", v, PRID);
        check("rst_epc_out", bus.epc_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd(5'd12, v); check("post_rst_sr", v, 32'd0);
        rd(5'd13, v); check("post_rst_cause", v, 32'd0);
        rd(5'd15, v); check("post_rst_prid", v, PRID);
        rd(5'd3, v);  check("unimpl_rd", v, 32'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.we       = vecs[i].we;
            bus.wr_addr  = vecs[i].wa;
            bus.wr_data  = vecs[i].wd;
            bus.pc       = vecs[i].pc;
            bus.bd       = vecs[i].bd;
            bus.exc_code = vecs[i].exc;
            bus.exl_clr  = vecs[i].clr;
            bus.hw_int   = vecs[i].hw;
            #1;
            check($sformatf("v%0d_req", i), {31'd0, bus.req}, {31'd0, vecs[i].req});
            @(posedge clk);
            #1;
            rd(5'd12, v); check($sformatf("v%0d_sr", i), v, vecs[i].sr);
            rd(5'd13, v); check($sformatf("v%0d_cause", i), v, vecs[i].cause);
            rd(5'd14, v); check($sformatf("v%0d_epc", i), v, vecs[i].epc);
            check($sformatf("v%0d_epc_out", i), bus.epc_out, vecs[i].epc);
        end

        // async reset mid-request: req must drop without a clock edge
        @(negedge clk);
        idle();
        bus.hw_int = 6'b000010;
        bus.pc     = 32'h0000_6000;
        #1;
        check("mid_req_before", {31'd0, bus.req}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_req_after", {31'd0, bus.req}, 32'd0);
        check("mid_epc_out", bus.epc_out, 32'd0);
        rd(5'd12, v); check("mid_sr", v, 32'd0);
        rd(5'd13, v); check("mid_cause", v, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        check("final_req", {31'd0, bus.req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
